// File: rtl/branch_lookup_table_if.sv
// Fetch/EX bus of the branch lookup table: the resolved-branch write port
// and the combinational fetch-PC lookup.
interface branch_lookup_table_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  write;
  logic [ADDR_WIDTH-1:0] write_key;
  logic [ADDR_WIDTH-1:0] write_val;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] read_key;
  logic [ADDR_WIDTH-1:0] read_val;
  logic                  read_valid;

  modport master (
    output write, write_key, write_val, hit, read_key,
    input  read_val, read_valid
  );

  modport slave (
    input  write, write_key, write_val, hit, read_key,
    output read_val, read_valid
  );
endinterface

// File: rtl/branch_lookup_table.sv
// Direct-mapped branch target buffer with per-entry taken prediction.
// Define BLT_COUNTER_EN for 2-bit saturating counters; default is 1-bit last-outcome.
module branch_lookup_table #(
  parameter int ADDR_WIDTH = 16,
  parameter int INDEX_BITS = 6
) (
  input logic                   clk,
  input logic                   reset,
  branch_lookup_table_if.slave  blt
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS;

`ifdef BLT_COUNTER_EN
  localparam int            SW      = 2;
  localparam logic [SW-1:0] ST_INIT = 2'd2;
`else
  localparam int            SW      = 1;
  localparam logic [SW-1:0] ST_INIT = 1'b1;
`endif

  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
  logic [SW-1:0]         r_state  [ENTRIES];

  logic                  w_write;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_wkey;
  logic [ADDR_WIDTH-1:0] w_wval;
  logic [ADDR_WIDTH-1:0] w_rkey;
  logic [INDEX_BITS-1:0] w_widx;
  logic [TAG_W-1:0]      w_wtag;
  logic [INDEX_BITS-1:0] w_ridx;
  logic [TAG_W-1:0]      w_rtag;
  logic                  w_wmatch;
  logic                  w_rmatch;
  logic                  w_rtaken;
  logic [SW-1:0]         w_wstate;
  logic [SW-1:0]         w_wstate_nxt;

  assign w_write = blt.write;
  assign w_hit   = blt.hit;
  assign w_wkey  = blt.write_key;
  assign w_wval  = blt.write_val;
  assign w_rkey  = blt.read_key;

  assign w_widx = w_wkey[INDEX_BITS-1:0];
  assign w_wtag = w_wkey[ADDR_WIDTH-1:INDEX_BITS];
  assign w_ridx = w_rkey[INDEX_BITS-1:0];
  assign w_rtag = w_rkey[ADDR_WIDTH-1:INDEX_BITS];

  // Read path: invalid or tag-mismatched entries never reach the outputs.
  assign w_rmatch = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
`ifdef BLT_COUNTER_EN
  assign w_rtaken = r_state[w_ridx][1];
`else
  assign w_rtaken = r_state[w_ridx][0];
`endif
  assign blt.read_val   = w_rmatch ? r_target[w_ridx] : '0;
  assign blt.read_valid = w_rmatch && w_rtaken;

  assign w_wmatch = r_valid[w_widx] && (r_tag[w_widx] == w_wtag);
  assign w_wstate = r_state[w_widx];

  always_comb begin
    w_wstate_nxt = w_wstate;
`ifdef BLT_COUNTER_EN
    if (w_hit) begin
      if (w_wstate != 2'd3) w_wstate_nxt = w_wstate + 2'd1;
    end else begin
      if (w_wstate != 2'd0) w_wstate_nxt = w_wstate - 2'd1;
    end
`else
    w_wstate_nxt = w_hit;
`endif
  end

  // Only valid bits are reset; payload fields are qualified by valid.
  // A not-taken write carries the fall-through address, so the target is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_write) begin
      if (w_wmatch) begin
        if (w_hit) r_target[w_widx] <= w_wval;
        r_state[w_widx] <= w_wstate_nxt;
      end else if (w_hit) begin
        r_valid[w_widx]  <= 1'b1;
        r_tag[w_widx]    <= w_wtag;
        r_target[w_widx] <= w_wval;
        r_state[w_widx]  <= ST_INIT;
      end
    end
  end
endmodule

// File: tb/tb_branch_lookup_table.sv
// Directed bench: the driver queues expected lookups, a negedge monitor checks them.
module tb_branch_lookup_table;
  logic clk;
  logic reset;
  logic rd_chk;
  int   n_checks;
  int   n_errors;

  typedef struct {
    string       nm;
    bit          v;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];

  branch_lookup_table_if #(.ADDR_WIDTH(16)) blt ();

  branch_lookup_table #(.ADDR_WIDTH(16), .INDEX_BITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .blt   (blt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BLT_COUNTER_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  // One cycle: drive write/read for this cycle, optionally queue the lookup expectation.
  task automatic cyc(input bit rst, input bit w, input logic [15:0] wk, input logic [15:0] wv,
                     input bit h, input logic [15:0] rk, input bit chk, input bit ev,
                     input logic [15:0] eval, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    blt.write     = w;
    blt.write_key = wk;
    blt.write_val = wv;
    blt.hit       = h;
    blt.read_key  = rk;
    rd_chk        = chk;
    if (chk) begin
      e.nm  = nm;
      e.v   = ev;
      e.val = eval;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_chk) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL monitor: lookup with empty scoreboard, got valid=%0b val=%h",
                 blt.read_valid, blt.read_val);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (blt.read_valid !== e.v) begin
          n_errors++;
          $display("FAIL %s valid: got %0b want %0b", e.nm, blt.read_valid, e.v);
        end
        n_checks++;
        if (blt.read_val !== e.val) begin
          n_errors++;
          $display("FAIL %s val: got %h want %h", e.nm, blt.read_val, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rd_chk   = 1'b0;
    reset    = 1'b1;
    blt.write = 1'b0; blt.write_key = '0; blt.write_val = '0; blt.hit = 1'b0; blt.read_key = '0;

    //   rst w  wkey     wval     h  rkey     chk ev   eval
    cyc(1, 0, 16'h0000, 16'h0000, 0, 16'h0010, 0, 0, 16'h0000, "rst");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, 0, 16'h0000, "reset_0010");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h013F, 1, 0, 16'h0000, "reset_013F");
    cyc(0, 1, 16'h0010, 16'h0040, 1, 16'h0010, 1, 0, 16'h0000, "no_bypass");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, 1, 16'h0040, "alloc_0010");
    cyc(0, 1, 16'h0020, 16'h0099, 0, 16'h0020, 1, 0, 16'h0000, "nt_same_cycle");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0020, 1, 0, 16'h0000, "nt_no_alloc");
    cyc(0, 0, 16'h0030, 16'h0077, 1, 16'h0030, 0, 0, 16'h0000, "w0_ignored");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0030, 1, 0, 16'h0000, "w0_no_alloc");
    // One not-taken: both schemes stop predicting, target retained.
    cyc(0, 1, 16'h0010, 16'h0011, 0, 16'h0010, 1, 1, 16'h0040, "pre_nt");
    cyc(0, 1, 16'h0010, 16'h0040, 1, 16'h0010, 1, 0, 16'h0040, "one_nt");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, 1, 16'h0040, "retaken");
    // Two not-taken then taken with new target.
    cyc(0, 1, 16'h0010, 16'h0011, 0, 16'h0000, 0, 0, 16'h0000, "nt1");
    cyc(0, 1, 16'h0010, 16'h0011, 0, 16'h0000, 0, 0, 16'h0000, "nt2");
    cyc(0, 1, 16'h0010, 16'h0044, 1, 16'h0010, 1, 0, 16'h0040, "after_2nt");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, !CNT, 16'h0044, "hyst_taken");
    // Saturate high, then a single not-taken.
    cyc(0, 1, 16'h0010, 16'h0044, 1, 16'h0000, 0, 0, 16'h0000, "t1");
    cyc(0, 1, 16'h0010, 16'h0044, 1, 16'h0000, 0, 0, 16'h0000, "t2");
    cyc(0, 1, 16'h0010, 16'h0044, 1, 16'h0000, 0, 0, 16'h0000, "t3");
    cyc(0, 1, 16'h0010, 16'h0055, 0, 16'h0000, 0, 0, 16'h0000, "nt_sat");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, CNT, 16'h0044, "sat_high");
    // Saturate low, then a single taken.
    cyc(0, 1, 16'h0010, 16'h0055, 0, 16'h0000, 0, 0, 16'h0000, "n1");
    cyc(0, 1, 16'h0010, 16'h0055, 0, 16'h0000, 0, 0, 16'h0000, "n2");
    cyc(0, 1, 16'h0010, 16'h0055, 0, 16'h0000, 0, 0, 16'h0000, "n3");
    cyc(0, 1, 16'h0010, 16'h0044, 1, 16'h0000, 0, 0, 16'h0000, "t_sat");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, !CNT, 16'h0044, "sat_low");
    // Alias eviction: 0x0050 shares index 0x10 with 0x0010.
    cyc(0, 1, 16'h0050, 16'h0070, 1, 16'h0000, 0, 0, 16'h0000, "alias_w");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, 0, 16'h0000, "evicted_0010");
    cyc(0, 1, 16'h0010, 16'h0011, 0, 16'h0050, 1, 1, 16'h0070, "alias_0050");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0050, 1, 1, 16'h0070, "nt_alias_kept");
    cyc(0, 1, 16'h013F, 16'h1234, 1, 16'h0000, 0, 0, 16'h0000, "w_013F");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h013F, 1, 1, 16'h1234, "top_index");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h003F, 1, 0, 16'h0000, "tag_mismatch");
    // Reset beats a simultaneous taken write.
    cyc(1, 1, 16'h0010, 16'h0040, 1, 16'h0000, 0, 0, 16'h0000, "rst_w");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, 0, 16'h0000, "rst_vs_w");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0050, 1, 0, 16'h0000, "rst_0050");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h013F, 1, 0, 16'h0000, "rst_013F");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, "idle");
    cyc(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, "idle");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
